// File: rtl/mac_pkg.sv
// Shared constants and elaboration helpers for the P-bit multiply-accumulate unit.
package mac_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Two guard bits above the full product width by default.
    function automatic int default_acc_w(input int p);
        return 2 * p + 2;
    endfunction

    function automatic bit params_ok(input int p, input int n, input int acc_w);
        return (acc_w >= 2 * p) && (n >= 1);
    endfunction

endpackage

// File: rtl/Full_Adder_P_bit.sv
// Ripple-carry adder of parameterised width, built from single-bit full adder cells.
module Full_Adder_P_bit #(
    parameter int P = 4
) (
    input  logic [P-1:0] a,
    input  logic [P-1:0] b,
    input  logic         cin,
    output logic [P-1:0] sum,
    output logic         cout
);

    logic [P:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < P; i++) begin : g_bit
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[P];

endmodule

// File: rtl/mac_unit_p_bit.sv
// Two-stage unsigned multiply-accumulate: stage 1 registers A*B, stage 2 accumulates
// N products and publishes the dot product with a one-cycle Done pulse.
module mac_unit_p_bit
    import mac_pkg::*;
#(
    parameter int P     = 4,
    parameter int N     = 4,
    parameter int ACC_W = default_acc_w(P),
    parameter int SAT   = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [P-1:0]     A,
    input  logic [P-1:0]     B,
    input  logic             In_valid,
    input  logic             Clear,
    output logic [ACC_W-1:0] Result,
    output logic             Done,
    output logic             Ovf,
    output logic             Busy
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    if (!params_ok(P, N, ACC_W)) begin : g_bad_params
        $error("mac_unit_p_bit: requires ACC_W >= 2*P and N >= 1");
    end

    logic [2*P-1:0]   prod_full;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] prod_reg;
    logic             p_valid;
    logic [ACC_W-1:0] acc;
    logic             ovf_acc;
    logic [CNT_W-1:0] count;
    logic [ACC_W-1:0] sum;
    logic             carry;
    logic [ACC_W-1:0] acc_next;
    logic             last_term;

    assign prod_full = A * B;
    assign prod_ext  = ACC_W'(prod_full);

    Full_Adder_P_bit #(
        .P (ACC_W)
    ) u_acc_adder (
        .a    (acc),
        .b    (prod_reg),
        .cin  (1'b0),
        .sum  (sum),
        .cout (carry)
    );

    // In saturating mode a carry pins the accumulator at all-ones; since the
    // accumulator then cannot grow, any further nonzero product carries again.
    assign acc_next  = ((SAT == MODE_SAT) && carry) ? {ACC_W{1'b1}} : sum;
    assign last_term = (count == CNT_W'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_reg <= '0;
            p_valid  <= 1'b0;
            acc      <= '0;
            ovf_acc  <= 1'b0;
            count    <= '0;
            Result   <= '0;
            Ovf      <= 1'b0;
            Done     <= 1'b0;
        end else begin
            Done <= 1'b0;
            // Clear overrides both the incoming term and a completing dot product.
            if (Clear) begin
                p_valid <= 1'b0;
                acc     <= '0;
                ovf_acc <= 1'b0;
                count   <= '0;
            end else begin
                p_valid  <= In_valid;
                prod_reg <= prod_ext;
                if (p_valid) begin
                    if (last_term) begin
                        Result  <= acc_next;
                        Ovf     <= ovf_acc | carry;
                        Done    <= 1'b1;
                        acc     <= '0;
                        ovf_acc <= 1'b0;
                        count   <= '0;
                    end else begin
                        acc     <= acc_next;
                        ovf_acc <= ovf_acc | carry;
                        count   <= count + 1'b1;
                    end
                end
            end
        end
    end

    assign Busy = p_valid | (count != '0);

endmodule

// File: tb/tb_mac_unit_p_bit.sv
// Drives three MAC configurations in parallel and checks every output each cycle
// against an integer-sum reference model of the dot-product behaviour.
module tb_mac_unit_p_bit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] A = '0;
    logic [3:0] B = '0;
    logic       In_valid = 1'b0;
    logic       Clear = 1'b0;

    logic [9:0] res0;
    logic [7:0] res1, res2;
    logic       done0, done1, done2;
    logic       ovf0, ovf1, ovf2;
    logic       busy0, busy1, busy2;

    always #5 clk = ~clk;

    mac_unit_p_bit #(.P(4), .N(4), .ACC_W(10), .SAT(0)) dut0 (
        .clk(clk), .rst(rst), .A(A), .B(B), .In_valid(In_valid), .Clear(Clear),
        .Result(res0), .Done(done0), .Ovf(ovf0), .Busy(busy0));

    mac_unit_p_bit #(.P(4), .N(2), .ACC_W(8), .SAT(0)) dut1 (
        .clk(clk), .rst(rst), .A(A), .B(B), .In_valid(In_valid), .Clear(Clear),
        .Result(res1), .Done(done1), .Ovf(ovf1), .Busy(busy1));

    mac_unit_p_bit #(.P(4), .N(2), .ACC_W(8), .SAT(1)) dut2 (
        .clk(clk), .rst(rst), .A(A), .B(B), .In_valid(In_valid), .Clear(Clear),
        .Result(res2), .Done(done2), .Ovf(ovf2), .Busy(busy2));

    int errors = 0;
    int checks = 0;
    int doneSeen0 = 0;

    // Reference model: a pending accepted term plus, per config, the running
    // integer total and term count of the unfinished dot product.
    int     mN   [3] = '{4, 2, 2};
    int     mW   [3] = '{10, 8, 8};
    int     mSat [3] = '{0, 0, 1};
    bit     pendV;
    longint pendP;
    int     cnt   [3];
    longint total [3];
    longint mRes  [3];
    bit     mOvf  [3];
    bit     mDone [3];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        pendV = 0;
        pendP = 0;
        for (int k = 0; k < 3; k++) begin
            cnt[k] = 0; total[k] = 0; mRes[k] = 0; mOvf[k] = 0; mDone[k] = 0;
        end
    endtask

    task automatic modelEdge();
        longint lim;
        if (rst) begin
            modelReset();
            return;
        end
        for (int k = 0; k < 3; k++) begin
            mDone[k] = 0;
            if (Clear) begin
                cnt[k] = 0;
                total[k] = 0;
            end else if (pendV) begin
                total[k] += pendP;
                cnt[k]++;
                if (cnt[k] == mN[k]) begin
                    lim = longint'(1) << mW[k];
                    mRes[k]  = mSat[k] ? ((total[k] >= lim) ? lim - 1 : total[k]) : (total[k] % lim);
                    mOvf[k]  = (total[k] >= lim);
                    mDone[k] = 1;
                    cnt[k] = 0;
                    total[k] = 0;
                end
            end
        end
        if (Clear) begin
            pendV = 0;
        end else begin
            pendV = In_valid;
            pendP = longint'(A) * longint'(B);
        end
    endtask

    task automatic checkAll(input string phase);
        checkOutput({phase, "_res0"},  32'(res0),  32'(mRes[0]));
        checkOutput({phase, "_res1"},  32'(res1),  32'(mRes[1]));
        checkOutput({phase, "_res2"},  32'(res2),  32'(mRes[2]));
        checkOutput({phase, "_done0"}, 32'(done0), 32'(mDone[0]));
        checkOutput({phase, "_done1"}, 32'(done1), 32'(mDone[1]));
        checkOutput({phase, "_done2"}, 32'(done2), 32'(mDone[2]));
        checkOutput({phase, "_ovf0"},  32'(ovf0),  32'(mOvf[0]));
        checkOutput({phase, "_ovf1"},  32'(ovf1),  32'(mOvf[1]));
        checkOutput({phase, "_ovf2"},  32'(ovf2),  32'(mOvf[2]));
        checkOutput({phase, "_busy0"}, 32'(busy0), 32'(pendV || cnt[0] != 0));
        checkOutput({phase, "_busy1"}, 32'(busy1), 32'(pendV || cnt[1] != 0));
        checkOutput({phase, "_busy2"}, 32'(busy2), 32'(pendV || cnt[2] != 0));
        if (done0 === 1'b1) doneSeen0++;
    endtask

    task automatic applyStimulus(input string phase, input logic [3:0] a, input logic [3:0] b,
                                 input logic v, input logic c);
        A = a;
        B = b;
        In_valid = v;
        Clear = c;
        @(posedge clk);
        modelEdge();
        #1;
        checkAll(phase);
    endtask

    task automatic idle(input string phase, input int n);
        for (int i = 0; i < n; i++) applyStimulus(phase, 4'd0, 4'd0, 1'b0, 1'b0);
    endtask

    logic [3:0] pa [4] = '{4'd3, 4'd1, 4'd3, 4'd2};
    logic [3:0] pb [4] = '{4'd1, 4'd2, 4'd3, 4'd1};

    initial begin
        modelReset();
        rst = 1'b1;
        #12;
        checkAll("reset");
        rst = 1'b0;
        idle("post_reset", 2);

        // Consecutive pairs form one dot product of 16.
        doneSeen0 = 0;
        for (int i = 0; i < 4; i++) applyStimulus("t1", pa[i], pb[i], 1'b1, 1'b0);
        idle("t1", 4);
        checkOutput("t1_result16", 32'(res0), 32'd16);
        checkOutput("t1_one_done", 32'(doneSeen0), 32'd1);

        // Same pairs separated by two idle cycles.
        doneSeen0 = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus("t2", pa[i], pb[i], 1'b1, 1'b0);
            idle("t2", 2);
        end
        idle("t2", 2);
        checkOutput("t2_result16", 32'(res0), 32'd16);
        checkOutput("t2_one_done", 32'(doneSeen0), 32'd1);

        // Overflow: 450 wraps to 194 or clamps to 255 at 8 bits.
        applyStimulus("t3", 4'd15, 4'd15, 1'b1, 1'b0);
        applyStimulus("t3", 4'd15, 4'd15, 1'b1, 1'b0);
        idle("t3", 3);
        checkOutput("t3_wrap194", 32'(res1), 32'd194);
        checkOutput("t3_wrap_ovf", 32'(ovf1), 32'd1);
        checkOutput("t3_sat255", 32'(res2), 32'd255);
        checkOutput("t3_sat_ovf", 32'(ovf2), 32'd1);
        applyStimulus("t3b", 4'd1, 4'd1, 1'b1, 1'b0);
        applyStimulus("t3b", 4'd2, 4'd2, 1'b1, 1'b0);
        idle("t3b", 3);
        checkOutput("t3b_res5", 32'(res1), 32'd5);
        checkOutput("t3b_ovf0", 32'(ovf1), 32'd0);

        // Clear mid dot product drops the pending pair and partial sum.
        applyStimulus("t4", 4'd0, 4'd0, 1'b0, 1'b1);
        idle("t4", 2);
        applyStimulus("t4", 4'd3, 4'd1, 1'b1, 1'b0);
        applyStimulus("t4", 4'd1, 4'd2, 1'b1, 1'b0);
        applyStimulus("t4", 4'd5, 4'd5, 1'b1, 1'b1);
        doneSeen0 = 0;
        for (int i = 0; i < 4; i++) applyStimulus("t4", 4'd1, 4'd1, 1'b1, 1'b0);
        idle("t4", 3);
        checkOutput("t4_result4", 32'(res0), 32'd4);
        checkOutput("t4_one_done", 32'(doneSeen0), 32'd1);

        // Asynchronous reset with three terms accumulated.
        for (int i = 0; i < 3; i++) applyStimulus("t5", 4'd7, 4'd9, 1'b1, 1'b0);
        applyStimulus("t5", 4'd0, 4'd0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkAll("t5_async");
        checkOutput("t5_busy_low", 32'(busy0), 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        doneSeen0 = 0;
        for (int i = 0; i < 4; i++) applyStimulus("t5b", 4'd2, 4'd3, 1'b1, 1'b0);
        idle("t5b", 3);
        checkOutput("t5b_result24", 32'(res0), 32'd24);
        checkOutput("t5b_one_done", 32'(doneSeen0), 32'd1);

        // Randomised traffic with gaps, occasional Clear and rare resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                applyStimulus("rnd_rst", 4'($urandom), 4'($urandom), 1'b1, 1'b0);
                rst = 1'b0;
            end else begin
                applyStimulus("rnd", 4'($urandom), 4'($urandom),
                              ($urandom_range(0, 9) < 7), ($urandom_range(0, 29) == 0));
            end
        end
        idle("drain", 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
